// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sched_pkg
//  Purpose  : Shared types for the data channel scheduler: FSM state
//             encoding, control packet layout and the "no node" id.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Control and data words share this layout: {node, len/payload}.
  typedef struct packed {
    logic [15:0] node;
    logic [15:0] len;
  } ctrl_pkt_t;

  localparam logic [15:0] NODE_NONE = 16'd0;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick over the pending request bits.
//             Returns the first pending node strictly after ptr, wrapping
//             to node 1; nodes above max_node are never chosen.
//  Ports    : pending  [MAX_NODES:1] request bits, one per node id
//             ptr      last granted node id
//             max_node runtime node count
//             winner   chosen node id (0 when none)
//             found    a winner exists
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int MAX_NODES = 4,
  parameter int NODE_W    = 16
) (
  input  logic [MAX_NODES:1] pending,
  input  logic [NODE_W-1:0]  ptr,
  input  logic [NODE_W-1:0]  max_node,
  output logic [NODE_W-1:0]  winner,
  output logic               found
);

  // Two ascending passes give circular order starting after ptr: first the
  // ids above ptr, then the ids from 1 up to ptr. Skipping ids above
  // max_node makes the wrap effectively happen at max_node.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= MAX_NODES; i++) begin
      if (!found && pending[i] && (NODE_W'(i) > ptr) && (NODE_W'(i) <= max_node)) begin
        found  = 1'b1;
        winner = NODE_W'(i);
      end
    end
    for (int i = 1; i <= MAX_NODES; i++) begin
      if (!found && pending[i] && (NODE_W'(i) <= ptr) && (NODE_W'(i) <= max_node)) begin
        found  = 1'b1;
        winner = NODE_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : data_channel_scheduler
//  Purpose  : Grants the shared data channel to one node at a time
//             (round-robin), tracks the granted transfer word by word and
//             releases the channel on completion or timeout.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             max_node            runtime node count
//             control_rx_packet   request {node, len}; 0 = none
//             control_tx_packet   grant {node, len}, one cycle
//             data_rx_packet      data word {node, payload}
//             data_rx_node_id     current channel owner, 0 when free
//             busy                high in GRANT/XFER/DONE
//             xfer_done           pulse: all granted words received
//             timeout_err         pulse: transfer aborted
//             req_drop            pulse: request rejected
//  Revision : 1.0  initial release
// ============================================================================
module data_channel_scheduler
  import sched_pkg::*;
#(
  parameter int MAX_NODES   = 4,
  parameter int NODE_W      = 16,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NODE_W-1:0] max_node,
  input  logic [31:0]       control_rx_packet,
  output logic [31:0]       control_tx_packet,
  input  logic [31:0]       data_rx_packet,
  output logic [NODE_W-1:0] data_rx_node_id,
  output logic              busy,
  output logic              xfer_done,
  output logic              timeout_err,
  output logic              req_drop
);

  localparam int                IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [NODE_W-1:0] MAX_ID = NODE_W'(MAX_NODES);

  // State
  sched_state_t      state_q, state_d;
  logic [MAX_NODES:1] pending_q, pending_d;
  logic [LEN_W-1:0]  len_tbl_q [1:MAX_NODES];
  logic [LEN_W-1:0]  len_tbl_d [1:MAX_NODES];
  logic [NODE_W-1:0] ptr_q, ptr_d;
  logic [NODE_W-1:0] cur_node_q, cur_node_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  // Registered outputs
  ctrl_pkt_t         tx_q, tx_d;
  logic [NODE_W-1:0] owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic              drop_q, drop_d;

  // Combinational helpers
  ctrl_pkt_t          req, word;
  logic [NODE_W-1:0]  winner;
  logic               found;
  logic [LEN_W-1:0]   winner_len;
  logic               grant_now;
  logic [MAX_NODES:1] req_onehot, clr_mask, pending_eff;
  logic               req_in_range, req_accept;
  logic               word_valid;
  logic [IDLE_W-1:0]  idle_inc;

  assign req  = ctrl_pkt_t'(control_rx_packet);
  assign word = ctrl_pkt_t'(data_rx_packet);

  rr_arbiter #(
    .MAX_NODES (MAX_NODES),
    .NODE_W    (NODE_W)
  ) u_arb (
    .pending  (pending_q),
    .ptr      (ptr_q),
    .max_node (max_node),
    .winner   (winner),
    .found    (found)
  );

  // Transfer FSM and output staging
  always_comb begin
    state_d     = state_q;
    cur_node_d  = cur_node_q;
    remaining_d = remaining_q;
    idle_d      = idle_q;
    ptr_d       = ptr_q;
    tx_d        = '0;
    owner_d     = NODE_NONE;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    to_d        = 1'b0;
    grant_now   = 1'b0;
    winner_len  = '0;
    word_valid  = 1'b0;
    idle_inc    = idle_q + IDLE_W'(1);

    for (int i = 1; i <= MAX_NODES; i++) begin
      if (winner == NODE_W'(i)) winner_len = len_tbl_q[i];
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_now   = 1'b1;
          state_d     = GRANT;
          cur_node_d  = winner;
          remaining_d = winner_len;
          ptr_d       = winner;
          idle_d      = '0;
          tx_d        = '{node: winner, len: winner_len};
          owner_d     = winner;
          busy_d      = 1'b1;
        end
      end
      GRANT: begin
        state_d = XFER;
        owner_d = cur_node_q;
        busy_d  = 1'b1;
      end
      XFER: begin
        // remaining never reaches 0 here in practice; the guard keeps the
        // counter from wrapping if it ever did.
        word_valid = (word.node == cur_node_q) && (remaining_q != '0);
        if (word_valid) begin
          remaining_d = remaining_q - LEN_W'(1);
          idle_d      = '0;
          busy_d      = 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            owner_d = cur_node_q;
          end
        end else begin
          idle_d = idle_inc;
          if (idle_inc == IDLE_W'(TIMEOUT_CYC)) begin
            state_d = IDLE;
            to_d    = 1'b1;
          end else begin
            owner_d = cur_node_q;
            busy_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request table. The pending check uses the table after this cycle's
  // grant clear, so the winner re-requesting on the grant edge is accepted
  // and its bit stays set.
  always_comb begin
    req_in_range = (req.node != NODE_NONE) && (req.node <= max_node) && (req.node <= MAX_ID);
    for (int i = 1; i <= MAX_NODES; i++) begin
      req_onehot[i] = (req.node == NODE_W'(i));
      clr_mask[i]   = grant_now && (winner == NODE_W'(i));
    end
    pending_eff = pending_q & ~clr_mask;
    req_accept  = req_in_range && (req.len != '0) && ((pending_eff & req_onehot) == '0);
    drop_d      = (control_rx_packet != 32'd0) && !req_accept;
    pending_d   = pending_eff | (req_accept ? req_onehot : '0);
    for (int i = 1; i <= MAX_NODES; i++) begin
      len_tbl_d[i] = (req_accept && req_onehot[i]) ? req.len : len_tbl_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      ptr_q       <= MAX_ID;
      cur_node_q  <= NODE_NONE;
      remaining_q <= '0;
      idle_q      <= '0;
      tx_q        <= '0;
      owner_q     <= NODE_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      to_q        <= 1'b0;
      drop_q      <= 1'b0;
      for (int i = 1; i <= MAX_NODES; i++) len_tbl_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      cur_node_q  <= cur_node_d;
      remaining_q <= remaining_d;
      idle_q      <= idle_d;
      tx_q        <= tx_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      to_q        <= to_d;
      drop_q      <= drop_d;
      for (int i = 1; i <= MAX_NODES; i++) len_tbl_q[i] <= len_tbl_d[i];
    end
  end

  assign control_tx_packet = tx_q;
  assign data_rx_node_id   = owner_q;
  assign busy              = busy_q;
  assign xfer_done         = done_q;
  assign timeout_err       = to_q;
  assign req_drop          = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_data_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_channel_scheduler
//  Purpose  : Self-checking bench for data_channel_scheduler: a vector table
//             for reset, single transfer, drops and round-robin order, plus
//             hand sequences for timeout and reset during a transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_channel_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] max_node;
  logic [31:0] control_rx_packet;
  logic [31:0] control_tx_packet;
  logic [31:0] data_rx_packet;
  logic [15:0] data_rx_node_id;
  logic        busy;
  logic        xfer_done;
  logic        timeout_err;
  logic        req_drop;

  data_channel_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .max_node          (max_node),
    .control_rx_packet (control_rx_packet),
    .control_tx_packet (control_tx_packet),
    .data_rx_packet    (data_rx_packet),
    .data_rx_node_id   (data_rx_node_id),
    .busy              (busy),
    .xfer_done         (xfer_done),
    .timeout_err       (timeout_err),
    .req_drop          (req_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] ctrl;
    logic [31:0] data;
    logic [31:0] tx;
    logic [15:0] owner;
    logic        busy;
    logic        done;
    logic        to;
    logic        drop;
  } vec_t;

  localparam int NV = 35;
  vec_t vt [NV];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(input logic r, input logic [31:0] c, input logic [31:0] d,
                              input logic [31:0] tx, input logic [15:0] ow, input logic b,
                              input logic dn, input logic t, input logic dr);
    vec_t v;
    v.rst = r; v.ctrl = c; v.data = d; v.tx = tx; v.owner = ow;
    v.busy = b; v.done = dn; v.to = t; v.drop = dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Inputs change just after a rising edge; outputs are read at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".tx"},    control_tx_packet, v.tx);
    chk({tag, ".owner"}, {16'd0, data_rx_node_id}, {16'd0, v.owner});
    chk({tag, ".busy"},  {31'd0, busy},        {31'd0, v.busy});
    chk({tag, ".done"},  {31'd0, xfer_done},   {31'd0, v.done});
    chk({tag, ".to"},    {31'd0, timeout_err}, {31'd0, v.to});
    chk({tag, ".drop"},  {31'd0, req_drop},    {31'd0, v.drop});
  endtask

  initial begin
    int n;
    int cyc;
    int seen_done;
    int seen_tx;
    //            rst  ctrl          data          tx            own b  dn to dr
    vt[0]  = mk(1, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
    vt[1]  = mk(1, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
    // single transfer, node 1 len 5
    vt[2]  = mk(0, 32'h00010005, 32'h0,        32'h0,        0, 0, 0, 0, 0);
    vt[3]  = mk(0, 32'h0,        32'h0,        32'h00010005, 1, 1, 0, 0, 0);
    vt[4]  = mk(0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 0);
    vt[5]  = mk(0, 32'h0,        32'h0001000A, 32'h0,        1, 1, 0, 0, 0);
    vt[6]  = mk(0, 32'h0,        32'h0001000B, 32'h0,        1, 1, 0, 0, 0);
    vt[7]  = mk(0, 32'h0,        32'h0001000C, 32'h0,        1, 1, 0, 0, 0);
    vt[8]  = mk(0, 32'h0,        32'h0001000D, 32'h0,        1, 1, 0, 0, 0);
    vt[9]  = mk(0, 32'h0,        32'h0001000E, 32'h0,        0, 1, 1, 0, 0);
    vt[10] = mk(0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
    // node 4 transfer; drops and queued requests while it runs
    vt[11] = mk(0, 32'h00040002, 32'h0,        32'h0,        0, 0, 0, 0, 0);
    vt[12] = mk(0, 32'h00010003, 32'h0,        32'h00040002, 4, 1, 0, 0, 0);
    vt[13] = mk(0, 32'h00010003, 32'h0,        32'h0,        4, 1, 0, 0, 1);
    vt[14] = mk(0, 32'h00050002, 32'h0,        32'h0,        4, 1, 0, 0, 1);
    vt[15] = mk(0, 32'h00020000, 32'h0,        32'h0,        4, 1, 0, 0, 1);
    vt[16] = mk(0, 32'h00030001, 32'h0,        32'h0,        4, 1, 0, 0, 0);
    vt[17] = mk(0, 32'h00020001, 32'h0,        32'h0,        4, 1, 0, 0, 0);
    vt[18] = mk(0, 32'h0,        32'h00040011, 32'h0,        4, 1, 0, 0, 0);
    vt[19] = mk(0, 32'h0,        32'h00040022, 32'h0,        0, 1, 1, 0, 0);
    vt[20] = mk(0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
    // round-robin after node 4: 1, then 2, then 3
    vt[21] = mk(0, 32'h0,        32'h0,        32'h00010003, 1, 1, 0, 0, 0);
    vt[22] = mk(0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 0);
    vt[23] = mk(0, 32'h0,        32'h00010001, 32'h0,        1, 1, 0, 0, 0);
    vt[24] = mk(0, 32'h0,        32'h00010002, 32'h0,        1, 1, 0, 0, 0);
    vt[25] = mk(0, 32'h0,        32'h00010003, 32'h0,        0, 1, 1, 0, 0);
    vt[26] = mk(0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
    vt[27] = mk(0, 32'h0,        32'h0,        32'h00020001, 2, 1, 0, 0, 0);
    vt[28] = mk(0, 32'h0,        32'h0,        32'h0,        2, 1, 0, 0, 0);
    vt[29] = mk(0, 32'h0,        32'h00020005, 32'h0,        0, 1, 1, 0, 0);
    vt[30] = mk(0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
    vt[31] = mk(0, 32'h0,        32'h0,        32'h00030001, 3, 1, 0, 0, 0);
    vt[32] = mk(0, 32'h0,        32'h0,        32'h0,        3, 1, 0, 0, 0);
    vt[33] = mk(0, 32'h0,        32'h00030009, 32'h0,        0, 1, 1, 0, 0);
    vt[34] = mk(0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);

    max_node          = 16'd4;
    rst               = 1'b1;
    control_rx_packet = '0;
    data_rx_packet    = '0;
    #1;

    for (int i = 0; i < NV; i++) begin
      rst               = vt[i].rst;
      control_rx_packet = vt[i].ctrl;
      data_rx_packet    = vt[i].data;
      tick();
      chk_all($sformatf("v%0d", i), vt[i]);
    end

    // Timeout: node 2 len 3, one good word, then foreign words until abort.
    control_rx_packet = 32'h00020003; data_rx_packet = '0;
    tick();
    control_rx_packet = '0;
    tick();
    chk("to.grant", control_tx_packet, 32'h00020003);
    tick();
    data_rx_packet = 32'h00020001;
    tick();
    chk("to.owner", {16'd0, data_rx_node_id}, 32'd2);
    data_rx_packet = 32'h00030007;
    n = 0; seen_done = 0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      tick();
      if (xfer_done) seen_done = 1;
      if (timeout_err) begin
        n = cyc;
        break;
      end
    end
    chk("to.cycles", n, 64);
    chk("to.no_done", seen_done, 0);
    chk("to.owner0", {16'd0, data_rx_node_id}, 32'd0);
    chk("to.busy0", {31'd0, busy}, 32'd0);
    data_rx_packet = '0;
    tick();
    chk("to.pulse", {31'd0, timeout_err}, 32'd0);
    chk("to.no_regrant", {31'd0, busy}, 32'd0);

    // Reset during a node 4 transfer while node 1 is pending.
    control_rx_packet = 32'h00040002;
    tick();
    control_rx_packet = '0;
    tick();
    chk("rst.grant", control_tx_packet, 32'h00040002);
    control_rx_packet = 32'h00010002;
    tick();
    control_rx_packet = '0;
    chk("rst.xfer", {16'd0, data_rx_node_id}, 32'd4);
    rst = 1'b1;
    tick();
    chk_all("rst.in", mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    seen_tx = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (control_tx_packet != 32'd0 || busy) seen_tx = 1;
    end
    chk("rst.no_grant", seen_tx, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
